// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the four-lane TDM demultiplexer.
package tdm_demux_pkg;
  localparam int LANES     = 4;
  localparam int ERR_LIMIT = 3;

  typedef logic [1:0] slot_t;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: clears on rst/clr, loads 1 on a sync beat, increments per beat.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  load_i,
  input  logic  inc_i,
  output slot_t slot_o,
  output logic  wrap_o
);
  slot_t slot_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i)  slot_q <= '0;
    else if (load_i)   slot_q <= slot_t'(1);
    else if (inc_i)    slot_q <= slot_q + slot_t'(1);
  end

  assign slot_o = slot_q;
  // Wrap marks the slot-3 beat that completes a frame.
  assign wrap_o = inc_i && !load_i && (slot_q == slot_t'(3));
endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: steers slot k of a framed beat stream to lane k.
// Optional realign checking is enabled by defining TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [3:0]       lane_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);
  state_t                       state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0]  dout_q;
  logic [LANES-1:0]             lane_valid_q;
  logic                         frame_done_q;
  slot_t                        slot, wr_lane;
  logic                         wr_en, load, inc, clr, wrap;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic [1:0]                   err_cnt_q, err_cnt_d;
  logic                         sync_err_q, sync_err_d;
`endif

  tdm_slot_ctr u_slot (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (load),
    .inc_i  (inc),
    .slot_o (slot),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_lane = '0;
    load    = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    err_cnt_d  = err_cnt_q;
    sync_err_d = 1'b0;
`endif
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          wr_en   = 1'b1;
          load    = 1'b1;
          state_d = LOCKED;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          err_cnt_d = '0;
`endif
        end
      end else if (frame_sync && slot != slot_t'(0)) begin
        // Realign: sync seen mid-frame restarts at slot 0.
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        sync_err_d = 1'b1;
        if (err_cnt_q == 2'(ERR_LIMIT - 1)) begin
          clr       = 1'b1;
          state_d   = HUNT;
          err_cnt_d = '0;
        end else begin
          wr_en     = 1'b1;
          load      = 1'b1;
          err_cnt_d = err_cnt_q + 2'd1;
        end
`else
        wr_en = 1'b1;
        load  = 1'b1;
`endif
      end else begin
        wr_en   = 1'b1;
        wr_lane = slot;
        inc     = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        if (slot == slot_t'(3)) err_cnt_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      dout_q       <= '0;
      lane_valid_q <= '0;
      frame_done_q <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      err_cnt_q    <= '0;
      sync_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lane_valid_q <= wr_en ? (LANES'(1) << wr_lane) : '0;
      frame_done_q <= wrap;
      if (wr_en) dout_q[wr_lane] <= din;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      err_cnt_q    <= err_cnt_d;
      sync_err_q   <= sync_err_d;
`endif
    end
  end

  assign dout0      = dout_q[0];
  assign dout1      = dout_q[1];
  assign dout2      = dout_q[2];
  assign dout3      = dout_q[3];
  assign lane_valid = lane_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == LOCKED);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign sync_err   = sync_err_q;
`else
  assign sync_err   = 1'b0;
`endif
endmodule
